// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions for the fetch sequencer: fetch state encoding,
// reset PC default, instruction alignment mask and small PC helpers.
package rv32i_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        FETCH_HOLD = 3'd3,
        FETCH_HALT = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] IALIGN_MASK      = 32'hFFFF_FFFC;
    localparam logic [31:0] ILEN_BYTES       = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return ((addr & ~IALIGN_MASK) != 32'd0);
    endfunction

    // Sequential successor; the 32-bit add wraps 0xFFFF_FFFC back to 0.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return (pc + ILEN_BYTES) & IALIGN_MASK;
    endfunction

endpackage

// File: rtl/rv32i_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem
// request at a time, buffers the returned word for decode, applies redirects.
module rv32i_fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  ifpc_q, ifpc_d;
    logic         kill_q, kill_d;
    logic         fault_q, fault_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic         redirect_ok_s;
    logic         redirect_bad_s;

    // Next-state, PC and buffer update; redirects take priority over sequential fetch.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        ifpc_d         = ifpc_q;
        kill_d         = kill_q;
        fault_d        = fault_q;
        redirect_ok_s  = redirect & ~is_misaligned(redirect_pc);
        redirect_bad_s = redirect & is_misaligned(redirect_pc);

        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (redirect_bad_s) begin
                    fault_d = 1'b1;
                    state_d = FETCH_HALT;
                end else if (redirect_ok_s) begin
                    pc_d = redirect_pc;
                    if (imem_gnt) begin
                        // The granted request still targets the old PC: drop its response.
                        kill_d  = 1'b1;
                        state_d = FETCH_WAIT;
                    end else begin
                        state_d = FETCH_REQ;
                    end
                end else if (imem_gnt) begin
                    state_d = FETCH_WAIT;
                end else begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (redirect_bad_s) begin
                    fault_d = 1'b1;
                    kill_d  = 1'b0;
                    state_d = FETCH_HALT;
                end else if (redirect_ok_s) begin
                    pc_d = redirect_pc;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = FETCH_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = FETCH_WAIT;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FETCH_REQ;
                    end else begin
                        instr_d = imem_rdata;
                        ifpc_d  = pc_q;
                        pc_d    = next_seq_pc(pc_q);
                        state_d = FETCH_HOLD;
                    end
                end else begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_HOLD: begin
                if (redirect_bad_s) begin
                    fault_d = 1'b1;
                    state_d = FETCH_HALT;
                end else if (redirect_ok_s) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH_REQ;
                end else if (id_ready) begin
                    state_d = FETCH_REQ;
                end else begin
                    state_d = FETCH_HOLD;
                end
            end
            FETCH_HALT: begin
                state_d = FETCH_HALT;
            end
            default: begin
                state_d = FETCH_IDLE;
                kill_d  = 1'b0;
            end
        endcase

        req_d   = (state_d == FETCH_REQ);
        valid_d = (state_d == FETCH_HOLD);
    end

    // State, PC, buffer and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            ifpc_q  <= RESET_PC;
            kill_q  <= 1'b0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            kill_q  <= kill_d;
            fault_q <= fault_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = ifpc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Self-checking bench for rv32i_fetch_ctrl: transaction-level model of the
// fetch contract compared every cycle, plus directed literal expectations.
module tb_rv32i_fetch_ctrl;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_fault;

    rv32i_fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(gnt), .imem_rvalid(rvalid), .imem_rdata(rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int hs_cyc[$];
    logic [31:0] hs_pc[$];
    logic [31:0] hs_instr[$];
    bit seen_dead = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Abstract model: flags for "started", "halted", "request outstanding",
    // "outstanding response is stale" and "buffer full".
    typedef struct {
        bit          started;
        bit          halted;
        bit          outst;
        bit          stale;
        bit          bufv;
        logic [31:0] pc;
        logic [31:0] binstr;
        logic [31:0] bpc;
    } model_t;

    model_t m = '{started: 1'b0, halted: 1'b0, outst: 1'b0, stale: 1'b0, bufv: 1'b0,
                  pc: RPC, binstr: 32'h0, bpc: RPC};

    function automatic bit fetching(input model_t s);
        return s.started && !s.halted && !s.outst && !s.bufv;
    endfunction

    function automatic model_t model_next(input model_t s);
        model_t n = s;
        bit req = fetching(s);
        if (rst) begin
            n = '{started: 1'b0, halted: 1'b0, outst: 1'b0, stale: 1'b0, bufv: 1'b0,
                  pc: RPC, binstr: 32'h0, bpc: RPC};
        end else if (!s.started) begin
            n.started = 1'b1;
        end else if (s.halted) begin
            n.halted = 1'b1;
        end else if (redirect) begin
            if (redirect_pc[1:0] != 2'b00) begin
                n.halted = 1'b1;
                n.bufv   = 1'b0;
            end else begin
                n.pc   = redirect_pc;
                n.bufv = 1'b0;
                if (req && gnt) begin
                    n.outst = 1'b1;
                    n.stale = 1'b1;
                end else if (s.outst) begin
                    n.outst = !rvalid;
                    n.stale = !rvalid;
                end
            end
        end else if (req) begin
            if (gnt) n.outst = 1'b1;
        end else if (s.outst) begin
            if (rvalid) begin
                n.outst = 1'b0;
                if (s.stale) begin
                    n.stale = 1'b0;
                end else begin
                    n.bufv   = 1'b1;
                    n.binstr = rdata;
                    n.bpc    = s.pc;
                    n.pc     = s.pc + 32'd4;
                end
            end
        end else if (s.bufv && id_ready) begin
            n.bufv = 1'b0;
        end
        return n;
    endfunction

    // Model advances on the same edge the DUT samples its inputs.
    always @(posedge clk) m <= model_next(m);

    // Single compare process, sampling 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        chk("imem_req", {31'b0, imem_req}, {31'b0, fetching(m)});
        if (fetching(m)) chk("imem_addr", imem_addr, m.pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m.bufv});
        if (m.bufv) begin
            chk("if_instr", if_instr, m.binstr);
            chk("if_pc", if_pc, m.bpc);
        end
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m.halted});
        if (if_valid && if_instr == DEAD) seen_dead = 1'b1;
        if (if_valid && id_ready) begin
            hs_cyc.push_back(cyc);
            hs_pc.push_back(if_pc);
            hs_instr.push_back(if_instr);
        end
    end

    bit auto_mem = 1'b0;
    bit pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    // Zero-wait memory: grant every request, return data the next cycle.
    task automatic respond();
        rvalid    = pend;
        rdata     = memf(pend_addr);
        pend      = imem_req;
        pend_addr = imem_addr;
        gnt       = imem_req;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (auto_mem) respond();
    endtask

    task automatic do_reset();
        auto_mem = 1'b0; pend = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; redirect = 1'b0; id_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Manual grant then response; must be called while in REQ.
    task automatic fetch_one(input logic [31:0] d);
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = d; tick();
        rvalid = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        // Reset state
        do_reset();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, RPC);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // Streaming with zero-wait memory and id_ready=1
        auto_mem = 1'b1; id_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("stream_hs_cnt", {31'b0, hs_pc.size() >= 3}, 32'd1);
        if (hs_pc.size() >= 3) begin
            chk("stream_pc0", hs_pc[0], 32'h0000_0100);
            chk("stream_pc1", hs_pc[1], 32'h0000_0104);
            chk("stream_pc2", hs_pc[2], 32'h0000_0108);
            chk("stream_instr0", hs_instr[0], 32'h5A5A_0113);
            chk("stream_gap01", hs_cyc[1] - hs_cyc[0], 32'd3);
            chk("stream_gap12", hs_cyc[2] - hs_cyc[1], 32'd3);
        end

        // Decode stall for 5 cycles in HOLD
        do_reset();
        auto_mem = 1'b1; id_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 5; i++) tick();
        chk("stall_valid", {31'b0, if_valid}, 32'd1);
        chk("stall_pc", if_pc, 32'h0000_0100);
        chk("stall_instr", if_instr, 32'h5A5A_0113);
        chk("stall_noreq", {31'b0, imem_req}, 32'd0);
        id_ready = 1'b1; tick();
        id_ready = 1'b0;
        chk("stall_rel_req", {31'b0, imem_req}, 32'd1);
        chk("stall_rel_addr", imem_addr, 32'h0000_0104);

        // Redirect in WAIT, stale rvalid two cycles later
        do_reset();
        tick();
        gnt = 1'b1; tick();
        gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200; tick();
        redirect = 1'b0; tick();
        rvalid = 1'b1; rdata = DEAD; tick();
        rvalid = 1'b0;
        chk("wait_redir_req", {31'b0, imem_req}, 32'd1);
        chk("wait_redir_addr", imem_addr, 32'h0000_0200);
        auto_mem = 1'b1; respond();
        tick(); tick();
        chk("wait_redir_pc", if_pc, 32'h0000_0200);
        chk("wait_redir_instr", if_instr, 32'h5A5A_0213);

        // Redirect coincident with grant
        do_reset();
        tick();
        gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200; tick();
        gnt = 1'b0; redirect = 1'b0; rvalid = 1'b1; rdata = DEAD; tick();
        rvalid = 1'b0;
        chk("gnt_redir_addr", imem_addr, 32'h0000_0200);
        chk("gnt_redir_req", {31'b0, imem_req}, 32'd1);
        fetch_one(memf(32'h0000_0200));
        chk("gnt_redir_pc", if_pc, 32'h0000_0200);

        // Redirect coincident with rvalid
        do_reset();
        tick();
        gnt = 1'b1; tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = DEAD;
        redirect = 1'b1; redirect_pc = 32'h0000_0200; tick();
        rvalid = 1'b0; redirect = 1'b0;
        chk("rv_redir_valid", {31'b0, if_valid}, 32'd0);
        chk("rv_redir_addr", imem_addr, 32'h0000_0200);

        // Redirect in REQ without grant, then wrap at top of address space
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick();
        redirect = 1'b0;
        chk("req_redir_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_one(32'h1234_5678);
        chk("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
        id_ready = 1'b1; tick();
        id_ready = 1'b0;
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Misaligned redirect from HOLD
        do_reset();
        tick();
        fetch_one(memf(RPC));
        redirect = 1'b1; redirect_pc = 32'h0000_0202; tick();
        redirect = 1'b0;
        chk("fault_set", {31'b0, fetch_fault}, 32'd1);
        chk("fault_valid", {31'b0, if_valid}, 32'd0);
        tick(); tick(); tick();
        chk("fault_noreq", {31'b0, imem_req}, 32'd0);
        rst = 1'b1; tick();
        chk("fault_cleared", {31'b0, fetch_fault}, 32'd0);
        rst = 1'b0; tick();
        chk("fault_restart_addr", imem_addr, RPC);

        // Reset while WAIT, stray rvalid afterwards
        do_reset();
        tick();
        gnt = 1'b1; tick();
        gnt = 1'b0; rst = 1'b1; tick();
        rst = 1'b0; rvalid = 1'b1; rdata = DEAD; tick();
        tick();
        rvalid = 1'b0;
        chk("stray_valid", {31'b0, if_valid}, 32'd0);
        fetch_one(memf(RPC));
        chk("stray_pc", if_pc, RPC);
        chk("stray_instr", if_instr, 32'h5A5A_0113);

        chk("never_dead", {31'b0, seen_dead}, 32'd0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
